mc_strobe_delay: RTL
====================

// Module: mc_strobe_delay
// PURPOSE
//  Parametrised multicycle data delay on a single pll_clock domain.
//  Generates an internal slow-grid strobe every DIV cycles at a programmable PHASE.
//  Moves LANES x WIDTH data plus a valid bit through a DEPTH-stage delay line that
//  advances only on the strobe. Sits between fast-clock arithmetic and multicycle
//  consumers that sample once per DIV cycles.
// PARAMETERS
//  WIDTH  32  bits per lane
//  LANES  1   number of parallel lanes sharing one strobe/valid
//  DIV    2   strobe period in pll_clock cycles; must be >=2
//  PHASE  0   cycle within the period at which the strobe fires; 0..DIV-1
//  DEPTH  1   slow-grid delay stages; must be >=1
// PORTS
//  pll_clock  in   1            sole clock, rising edge
//  reset_n    in   1            asynchronous, active-low reset
//  sync       in   1            realign pulse: forces phase counter to 0
//  data_in    in   WIDTH*LANES  lane k at [k*WIDTH +: WIDTH]
//  valid_in   in   1            qualifies data_in
//  data_out   out  WIDTH*LANES  delayed data, same lane order
//  valid_out  out  1            delayed valid
//  strobe     out  1            high for one cycle per DIV, when cnt==PHASE
//  hold_err   out  1            sticky stability error (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (async, reset_n=0):
//    - cnt, data_fast, valid_fast, all slow stages and hold_err clear to 0.
//    - data_out=0, valid_out=0, strobe=(PHASE==0).
//  - Phase counter cnt ($clog2(DIV) bits):
//    - Increments modulo DIV every cycle.
//    - sync=1 loads 0 next cycle and overrides the increment.
//  - strobe is a decode of the cnt register only; no combinational path from any input.
//  - Fast capture (every cycle):
//    - data_fast <= data_in
//    - valid_fast <= valid_in
//  - On a strobe cycle, the line shifts:
//    - slow[0] <= {valid_fast, data_fast}
//    - slow[k] <= slow[k-1]
//    - Between strobes all slow stages hold.
//  - data_out/valid_out = slow[DEPTH-1] (registered); no other logic on the output path.
//  - Latency:
//    - data_in presented in cycle t-1, where cycle t is a strobe cycle, appears on
//      data_out after the edge ending cycle t+(DEPTH-1)*DIV.
//    - Output updates once per DIV cycles.
//  - Source contract: data_in stable for the cycle before each strobe and the strobe
//    cycle itself. Values present only outside that window are dropped.
//  - sync in a strobe cycle: the shift still occurs; cnt goes to 0 next cycle.
//  - Asserting reset_n mid-operation:
//    - Clears the line immediately; valid_out drops asynchronously.
//    - In-flight data is discarded.
//    - Post-release, the first strobe fires at cycle PHASE.
//  - Elaboration $error if DIV<2, PHASE>=DIV or DEPTH<1.
// CONFIGURATION
//  - MC_DELAY_HOLD_CHECK_EN defined:
//    - In a strobe cycle with valid_fast=1 and data_in!=data_fast, hold_err <= 1.
//    - hold_err stays sticky until reset.
//  - Not defined: hold_err tied 0; no compare logic is built.
// TESTING
//  1. DIV=4, PHASE=1, release reset_n -> strobe high in cycles 1,5,9; data_out=0 and
//     valid_out=0 until the first shift.
//  2. DIV=2, DEPTH=3, hold 0xDEADBEEF with valid=1 in cycles t-1..t (t = strobe)
//     -> data_out=0xDEADBEEF, valid_out=1 after edge ending t+4.
//  3. DIV=4, PHASE=0, sync=1 while cnt=2 -> cnt=0 next cycle, strobe that cycle;
//     the next strobe follows 4 cycles later.
//  4. LANES=4, WIDTH=8, data_in=0x44332211 valid -> data_out=0x44332211
//     (lane order kept) after the latency of test 2.
//  5. valid_out=1, drop reset_n mid-cycle -> valid_out=0 and data_out=0 immediately;
//     re-release behaves as test 1.
//  6. MC_DELAY_HOLD_CHECK_EN: change data_in 0x1 -> 0x2 in a strobe cycle with
//     valid=1 -> hold_err=1 and stays 1. Without the macro, hold_err=0 throughout.

Source files
------------

// File: rtl/mc_strobe_delay.sv
// Multicycle strobe-gated delay line: a DIV-cycle strobe at PHASE shifts LANES x WIDTH
// data plus valid through DEPTH slow stages. Optional stability check: MC_DELAY_HOLD_CHECK_EN.
module mc_strobe_delay #(
    parameter int WIDTH = 32,
    parameter int LANES = 1,
    parameter int DIV   = 2,
    parameter int PHASE = 0,
    parameter int DEPTH = 1
) (
    input  logic                     pll_clock,
    input  logic                     reset_n,
    input  logic                     sync,
    input  logic [WIDTH*LANES-1:0]   data_in,
    input  logic                     valid_in,
    output logic [WIDTH*LANES-1:0]   data_out,
    output logic                     valid_out,
    output logic                     strobe,
    output logic                     hold_err
);
    localparam int W  = WIDTH * LANES;
    localparam int CW = (DIV < 2) ? 1 : $clog2(DIV);

    if (DIV < 2) begin : g_bad_div
        $error("mc_strobe_delay: DIV must be >= 2");
    end
    if (PHASE < 0 || PHASE >= DIV) begin : g_bad_phase
        $error("mc_strobe_delay: PHASE must be in 0..DIV-1");
    end
    if (DEPTH < 1) begin : g_bad_depth
        $error("mc_strobe_delay: DEPTH must be >= 1");
    end

    logic [CW-1:0] cnt;
    logic [W-1:0]  data_fast;
    logic          valid_fast;
    logic [W:0]    slow [DEPTH];

    always_ff @(posedge pll_clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (sync) begin
            cnt <= '0;
        end else if (cnt == CW'(DIV - 1)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Decoded from the counter register only, so strobe never depends on an input.
    assign strobe = (cnt == CW'(PHASE));

    // valid_in qualifies data_in in the same cycle; there is no backpressure, the
    // source must hold both for the cycle before a strobe and the strobe cycle.
    always_ff @(posedge pll_clock or negedge reset_n) begin
        if (!reset_n) begin
            data_fast  <= '0;
            valid_fast <= 1'b0;
        end else begin
            data_fast  <= data_in;
            valid_fast <= valid_in;
        end
    end

    always_ff @(posedge pll_clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                slow[k] <= '0;
            end
        end else if (strobe) begin
            slow[0] <= {valid_fast, data_fast};
            for (int k = 1; k < DEPTH; k++) begin
                slow[k] <= slow[k-1];
            end
        end
    end

    assign valid_out = slow[DEPTH-1][W];
    assign data_out  = slow[DEPTH-1][W-1:0];

`ifdef MC_DELAY_HOLD_CHECK_EN
    // Flags a source that moved data_in inside the capture window of a valid word.
    always_ff @(posedge pll_clock or negedge reset_n) begin
        if (!reset_n) begin
            hold_err <= 1'b0;
        end else if (strobe && valid_fast && (data_in != data_fast)) begin
            hold_err <= 1'b1;
        end
    end
`else
    assign hold_err = 1'b0;
`endif

endmodule
